// File: rtl/ps2_host_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ps2_host_tx_pkg                                        |
// | Description : Shared PS/2 state encodings, command constants and     |
// |               default timing values for the PS/2 host path.          |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_DATA      = 3'd3,
        ST_PARITY    = 3'd4,
        ST_STOP      = 3'd5,
        ST_ACK       = 3'd6,
        ST_WAIT_IDLE = 3'd7
    } state_t;

    localparam logic [7:0] c_CMD_SET_LED = 8'hED;
    localparam logic [7:0] c_CMD_RESET   = 8'hFF;
    localparam logic [7:0] c_RSP_ACK     = 8'hFA;
    localparam logic [7:0] c_KEY_ENTER   = 8'h5A;

    localparam int c_DEF_INHIBIT_CYCLES = 5000;
    localparam int c_DEF_TIMEOUT_CYCLES = 1000000;
    localparam int c_DEF_FILTER_LEN     = 4;

    // PS/2 frames carry odd parity over the eight data bits
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ps2_host_tx_if                                         |
// | Description : Command handshake between a requester and the PS/2     |
// |               host transmitter.                                      |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       tx_done;
    logic       tx_err;

    modport master (output tx_data, output tx_start,
                    input  busy, input tx_done, input tx_err);
    modport slave  (input  tx_data, input tx_start,
                    output busy, output tx_done, output tx_err);
endinterface
`default_nettype wire

// File: rtl/ps2_host_tx_line_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ps2_host_tx_line_sync                                  |
// | Description : 2-FF synchroniser plus glitch filter on the PS/2 clock |
// |               and data lines, with a falling-edge strobe on clock.   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module ps2_host_tx_line_sync #(
    parameter int FILTER_LEN = 4
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clk_in,
    input  wire logic data_in,
    output logic      clk_filt,
    output logic      data_filt,
    output logic      clk_fall
);

    localparam int c_CW = $clog2(FILTER_LEN + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(FILTER_LEN - 1);

    logic [1:0] w_raw;
    logic [1:0] w_filt;
    logic       r_clk_d;

    assign w_raw = {data_in, clk_in};

    for (genvar gi = 0; gi < 2; gi++) begin : g_line
        logic [1:0]      r_sync;
        logic [c_CW-1:0] r_cnt;
        logic            r_level;

        // Lines idle high; a new level is accepted only after FILTER_LEN equal samples
        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync  <= 2'b11;
                r_cnt   <= '0;
                r_level <= 1'b1;
            end else begin
                r_sync <= {r_sync[0], w_raw[gi]};
                if (r_sync[1] == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_LAST) begin
                    r_level <= r_sync[1];
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_filt[gi] = r_level;
    end

    // Delayed filtered clock for edge detection
    always_ff @(posedge clk) begin
        if (reset) r_clk_d <= 1'b1;
        else       r_clk_d <= w_filt[0];
    end

    assign clk_filt  = w_filt[0];
    assign data_filt = w_filt[1];
    assign clk_fall  = r_clk_d & ~w_filt[0];

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ps2_host_tx                                            |
// | Description : PS/2 host-to-device command transmitter: inhibit,      |
// |               request-to-send, 8 data + parity + stop, ack/timeout.  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = c_DEF_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = c_DEF_TIMEOUT_CYCLES,
    parameter int FILTER_LEN     = c_DEF_FILTER_LEN
) (
    input  wire logic     clk,
    input  wire logic     reset,
    ps2_host_tx_if.slave  bus,
    input  wire logic     ps2_clk_in,
    input  wire logic     ps2_data_in,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);

    localparam int c_MAX_CYC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC) + 1;
    localparam logic [c_CNT_W-1:0] c_INH_START = c_CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [c_CNT_W-1:0] c_INH_LAST  = c_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic w_clk_f;
    logic w_data_f;
    logic w_fall;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [3:0]           r_bit;
    logic [7:0]           r_shift;
    logic                 r_par;
    logic                 r_clk_oe;
    logic                 r_data_oe;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    ps2_host_tx_line_sync #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_sync (
        .clk       (clk),
        .reset     (reset),
        .clk_in    (ps2_clk_in),
        .data_in   (ps2_data_in),
        .clk_filt  (w_clk_f),
        .data_filt (w_data_f),
        .clk_fall  (w_fall)
    );

    // Transfer sequencer; one counter serves both the inhibit interval and the timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.tx_start) begin
                        r_shift  <= bus.tx_data;
                        r_par    <= odd_parity(bus.tx_data);
                        r_busy   <= 1'b1;
                        r_clk_oe <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Start bit goes low while the clock is still held, then clock is freed
                    if (r_cnt == c_INH_START) r_data_oe <= 1'b1;
                    if (r_cnt == c_INH_LAST) begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b1;
                        r_cnt     <= '0;
                        r_bit     <= '0;
                        r_state   <= ST_REQ;
                    end
                end
                default: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_TMO_LAST) begin
                        // Timeout has priority over any clock fall in the same cycle
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_busy    <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        case (r_state)
                            ST_REQ: begin
                                if (w_fall) begin
                                    r_data_oe <= ~r_shift[0];
                                    r_shift   <= {1'b0, r_shift[7:1]};
                                    r_bit     <= 4'd1;
                                    r_state   <= ST_DATA;
                                end
                            end
                            ST_DATA: begin
                                if (w_fall) begin
                                    r_bit <= r_bit + 1'b1;
                                    if (r_bit == 4'd8) begin
                                        r_data_oe <= ~r_par;
                                        r_state   <= ST_PARITY;
                                    end else begin
                                        r_data_oe <= ~r_shift[0];
                                        r_shift   <= {1'b0, r_shift[7:1]};
                                    end
                                end
                            end
                            ST_PARITY: begin
                                if (w_fall) begin
                                    r_data_oe <= 1'b0;
                                    r_bit     <= r_bit + 1'b1;
                                    r_state   <= ST_STOP;
                                end
                            end
                            ST_STOP: begin
                                r_state <= ST_ACK;
                            end
                            ST_ACK: begin
                                if (w_fall) begin
                                    if (!w_data_f) begin
                                        r_state <= ST_WAIT_IDLE;
                                    end else begin
                                        r_busy  <= 1'b0;
                                        r_err   <= 1'b1;
                                        r_state <= ST_IDLE;
                                    end
                                end
                            end
                            default: begin
                                if (w_clk_f && w_data_f) begin
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                    r_state <= ST_IDLE;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign bus.busy    = r_busy;
    assign bus.tx_done = r_done;
    assign bus.tx_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ps2_host_tx                                         |
// | Description : Self-checking bench for ps2_host_tx with a PS/2 device |
// |               model and a completion scoreboard.                     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_ps2_host_tx;

    localparam int c_HALF = 40;

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic       par;
        int         glitch;
        int         mid;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic ps2_clk_oe;
    logic ps2_data_oe;
    logic bfm_clk_low  = 1'b0;
    logic bfm_data_low = 1'b0;
    logic ps2_clk_line;
    logic ps2_data_line;

    int total = 0;
    int bad   = 0;
    int run_len  = 0;
    int last_run = 0;
    int n_pulse  = 0;
    logic [1:0] q_res [$];
    vec_t vecs [5];

    ps2_host_tx_if bus ();

    assign ps2_clk_line  = ~(ps2_clk_oe  | bfm_clk_low);
    assign ps2_data_line = ~(ps2_data_oe | bfm_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (50),
        .TIMEOUT_CYCLES (20000),
        .FILTER_LEN     (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Completion monitor: every pulse must match the oldest expected result
    always @(posedge clk) begin
        #1;
        if (ps2_clk_oe) run_len++;
        else if (run_len > 0) begin
            last_run = run_len;
            run_len  = 0;
        end
        if (bus.tx_done || bus.tx_err) begin
            n_pulse++;
            if (q_res.size() == 0) check("unexpected_pulse", {30'd0, bus.tx_done, bus.tx_err}, 32'd0);
            else check("result_kind", {30'd0, bus.tx_done, bus.tx_err}, {30'd0, q_res.pop_front()});
        end
    end

    task automatic send_start(input logic [7:0] d);
        bus.tx_data  = d;
        bus.tx_start = 1'b1;
        tick(1);
        bus.tx_start = 1'b0;
        check("busy_on_accept", bus.busy, 1);
    endtask

    // Device model: clocks the frame, samples data on each rising edge
    task automatic bfm_frame(input logic ack, input int glitch, input int mid, input int abort,
                             output logic [9:0] rx, output bit ok);
        int w;
        rx = '0;
        ok = 1'b0;
        w  = 0;
        while (!(ps2_clk_line && !ps2_data_line) && w < 300) begin
            tick(1);
            w++;
        end
        if (w >= 300) begin
            check("request_seen", 0, 1);
            return;
        end
        tick(20);
        for (int i = 1; i <= 10; i++) begin
            bfm_clk_low = 1'b1;
            tick(c_HALF);
            bfm_clk_low = 1'b0;
            rx[i-1] = ps2_data_line;
            if (i == abort) return;
            if (i == glitch) begin
                tick(10);
                bfm_clk_low = 1'b1;
                tick(1);
                bfm_clk_low = 1'b0;
                tick(c_HALF - 11);
            end else if (i == mid) begin
                tick(5);
                bus.tx_data  = 8'h55;
                bus.tx_start = 1'b1;
                tick(1);
                bus.tx_start = 1'b0;
                tick(c_HALF - 6);
            end else begin
                tick(c_HALF);
            end
        end
        if (ack) bfm_data_low = 1'b1;
        tick(10);
        bfm_clk_low = 1'b1;
        tick(c_HALF);
        bfm_clk_low = 1'b0;
        tick(10);
        bfm_data_low = 1'b0;
        ok = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [9:0] rx;
        bit ok;
        int w;
        q_res.push_back(v.ack ? 2'b10 : 2'b01);
        send_start(v.data);
        bfm_frame(v.ack, v.glitch, v.mid, 0, rx, ok);
        if (ok) begin
            check("rx_byte", rx[7:0], v.data);
            check("rx_parity", rx[8], v.par);
            check("rx_stop", rx[9], 1);
        end
        check("inhibit_len", last_run, 50);
        w = 0;
        while (q_res.size() != 0 && w < 500) begin
            tick(1);
            w++;
        end
        check("result_pending", q_res.size(), 0);
        tick(100);
        check("busy_after", bus.busy, 0);
        check("lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
    endtask

    initial begin
        logic [9:0] rx;
        bit ok;
        int t;
        int snap;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 0, 0};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 0, 0};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 0, 0};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 0, 0};
        vecs[4] = '{8'hA3, 1'b1, 1'b1, 3, 5};

        reset        = 1'b1;
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        tick(3);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.tx_done, 0);
        check("rst_err", bus.tx_err, 0);
        reset = 1'b0;
        tick(5);

        for (int k = 0; k < 5; k++) run_vec(vecs[k]);

        // No device clocking: timeout counted from clock release
        q_res.push_back(2'b01);
        send_start(8'hED);
        t = 0;
        while (ps2_clk_oe && t < 200) begin
            tick(1);
            t++;
        end
        t = 0;
        while (!bus.tx_err && t < 25000) begin
            tick(1);
            t++;
        end
        check("timeout_cycles", t, 20000);
        check("timeout_lines", {ps2_clk_oe, ps2_data_oe}, 0);
        check("timeout_busy", bus.busy, 0);
        tick(5);
        check("timeout_scoreboard", q_res.size(), 0);

        // Reset after the fourth data bit, then a fresh command
        q_res.push_back(2'b10);
        send_start(8'hED);
        bfm_frame(1'b1, 0, 0, 4, rx, ok);
        check("pre_reset_bits", rx[3:0], 4'hD);
        snap  = n_pulse;
        reset = 1'b1;
        q_res.delete();
        tick(1);
        check("mid_rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        check("mid_rst_busy", bus.busy, 0);
        reset = 1'b0;
        tick(30);
        check("mid_rst_no_pulse", n_pulse, snap);
        run_vec('{8'hFF, 1'b1, 1'b1, 0, 0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
